// File: rtl/dma_apb_cfg_mc_pkg.sv
// Shared widths, register offsets and enums for the multi-channel DMA APB config block.
package dma_apb_cfg_mc_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 12;
    localparam int unsigned REG_DATA_WIDTH = 32;
    localparam int unsigned MODE_WIDTH     = 2;

    localparam int unsigned CH_SRC_OFS  = 'h0;
    localparam int unsigned CH_DEST_OFS = 'h4;
    localparam int unsigned CH_SIZE_OFS = 'h8;
    localparam int unsigned CH_MODE_OFS = 'hC;

    localparam int unsigned GLB_INT_STAT_OFS = 'h0;
    localparam int unsigned GLB_INT_EN_OFS   = 'h4;
    localparam int unsigned GLB_BUSY_OFS     = 'h8;
    localparam int unsigned GLB_SPAN         = 'hC;

    typedef enum logic [1:0] {MODE_IDLE, MODE_NORMAL, MODE_VERIFY} dma_mode_e;
    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;

endpackage

// File: rtl/dma_apb_chan_regs.sv
// One DMA channel: SRC/DEST/SIZE/MODE registers, busy tracking and start pulse.
module dma_apb_chan_regs
    import dma_apb_cfg_mc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write,
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] addr,
    input  logic [REG_DATA_WIDTH-1:0] wdata,
    input  logic                      done,
    output logic [REG_DATA_WIDTH-1:0] rd_data_c,
    output logic                      err_c,
    output logic                      done_set_c,
    output logic [REG_DATA_WIDTH-1:0] src,
    output logic [REG_DATA_WIDTH-1:0] dest,
    output logic [REG_DATA_WIDTH-1:0] size,
    output logic [MODE_WIDTH-1:0]     mode,
    output logic                      start,
    output logic                      busy
);

    logic zero_done;

    // Zero-length starts complete on their own one cycle after the commit.
    assign done_set_c = (done && busy) || zero_done;

    // Read mux and access checks for this channel's register window.
    always_comb begin
        rd_data_c = '0;
        err_c     = 1'b0;
        case (addr)
            REG_ADDR_WIDTH'(CH_SRC_OFS):  rd_data_c = src;
            REG_ADDR_WIDTH'(CH_DEST_OFS): rd_data_c = dest;
            REG_ADDR_WIDTH'(CH_SIZE_OFS): rd_data_c = size;
            REG_ADDR_WIDTH'(CH_MODE_OFS): begin
                rd_data_c = REG_DATA_WIDTH'(mode);
                if (write && (wdata > REG_DATA_WIDTH'(MODE_VERIFY))) err_c = 1'b1;
            end
            default: err_c = 1'b1;
        endcase
        if (write && busy) err_c = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src       <= '0;
            dest      <= '0;
            size      <= '0;
            mode      <= MODE_WIDTH'(MODE_IDLE);
            start     <= 1'b0;
            busy      <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            start     <= 1'b0;
            zero_done <= 1'b0;
            if (done_set_c) begin
                busy <= 1'b0;
                mode <= MODE_WIDTH'(MODE_IDLE);
            end
            // Writes only commit on an idle channel, so they never race the done path.
            if (wr_en) begin
                case (addr)
                    REG_ADDR_WIDTH'(CH_SRC_OFS):  src  <= wdata;
                    REG_ADDR_WIDTH'(CH_DEST_OFS): dest <= wdata;
                    REG_ADDR_WIDTH'(CH_SIZE_OFS): size <= wdata;
                    REG_ADDR_WIDTH'(CH_MODE_OFS): begin
                        if (wdata[MODE_WIDTH-1:0] != MODE_WIDTH'(MODE_IDLE)) begin
                            mode <= wdata[MODE_WIDTH-1:0];
                            if (size != '0) begin
                                busy  <= 1'b1;
                                start <= 1'b1;
                            end else begin
                                zero_done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/dma_apb_cfg_mc.sv
// APB slave for an NCH-channel DMA: transfer FSM, address decode, global IRQ registers.
module dma_apb_cfg_mc
    import dma_apb_cfg_mc_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned CH_STRIDE   = 32,
    parameter int unsigned GLB_BASE    = 256
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [REG_ADDR_WIDTH-1:0]     PADDR,
    input  logic [REG_DATA_WIDTH-1:0]     PWDATA,
    output logic [REG_DATA_WIDTH-1:0]     PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    output logic [NCH*REG_DATA_WIDTH-1:0] ch_src,
    output logic [NCH*REG_DATA_WIDTH-1:0] ch_dest,
    output logic [NCH*REG_DATA_WIDTH-1:0] ch_size,
    output logic [NCH*MODE_WIDTH-1:0]     ch_mode,
    output logic [NCH-1:0]                ch_start,
    input  logic [NCH-1:0]                ch_done,
    output logic                          INTR
);

    apb_state_e                state;
    logic [2:0]                wait_cnt;
    logic [NCH-1:0]            int_status;
    logic [NCH-1:0]            int_enable;
    logic [NCH-1:0]            ch_busy;
    logic [NCH-1:0]            done_set;
    logic [NCH-1:0]            ch_err;
    logic [NCH-1:0]            ch_sel;
    logic [REG_DATA_WIDTH-1:0] ch_rd [NCH];

    logic [31:0]               addr32;
    logic [31:0]               ch_idx;
    logic [31:0]               ch_ofs;
    logic [31:0]               glb_ofs;
    logic                      ch_hit;
    logic                      glb_hit;
    logic                      err_c;
    logic [REG_DATA_WIDTH-1:0] rd_c;
    logic [REG_DATA_WIDTH-1:0] ch_rd_sel;
    logic [REG_DATA_WIDTH-1:0] glb_rd;
    logic                      ch_err_sel;
    logic                      glb_err;
    logic                      wr_commit;

    // A write takes effect only at the end of an error-free PREADY cycle.
    assign wr_commit = PREADY && !PSLVERR && PSEL && PENABLE && PWRITE;

    // Address decode, access checks and read mux.
    always_comb begin
        addr32     = 32'(PADDR);
        ch_idx     = addr32 / CH_STRIDE;
        ch_ofs     = addr32 % CH_STRIDE;
        glb_ofs    = addr32 - GLB_BASE;
        ch_hit     = addr32 < (NCH * CH_STRIDE);
        glb_hit    = (addr32 >= GLB_BASE) && (addr32 < (GLB_BASE + GLB_SPAN));
        ch_sel     = '0;
        ch_rd_sel  = '0;
        ch_err_sel = 1'b0;
        for (int c = 0; c < int'(NCH); c++) begin
            if (ch_hit && (ch_idx == 32'(c))) begin
                ch_sel[c]  = 1'b1;
                ch_rd_sel  = ch_rd[c];
                ch_err_sel = ch_err[c];
            end
        end
        glb_rd  = '0;
        glb_err = 1'b0;
        case (glb_ofs)
            32'(GLB_INT_STAT_OFS): glb_rd = REG_DATA_WIDTH'(int_status);
            32'(GLB_INT_EN_OFS):   glb_rd = REG_DATA_WIDTH'(int_enable);
            32'(GLB_BUSY_OFS): begin
                glb_rd  = REG_DATA_WIDTH'(ch_busy);
                glb_err = PWRITE;
            end
            default: ;
        endcase
        err_c = (PADDR[1:0] != 2'b00) || (!ch_hit && !glb_hit) ||
                (ch_hit && ch_err_sel) || (glb_hit && glb_err);
        rd_c  = err_c ? '0 : (ch_hit ? ch_rd_sel : glb_rd);
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        dma_apb_chan_regs u_chan (
            .clk        (CLK),
            .rst        (RST),
            .write      (PWRITE),
            .wr_en      (wr_commit && ch_sel[c]),
            .addr       (REG_ADDR_WIDTH'(ch_ofs)),
            .wdata      (PWDATA),
            .done       (ch_done[c]),
            .rd_data_c  (ch_rd[c]),
            .err_c      (ch_err[c]),
            .done_set_c (done_set[c]),
            .src        (ch_src[c*REG_DATA_WIDTH +: REG_DATA_WIDTH]),
            .dest       (ch_dest[c*REG_DATA_WIDTH +: REG_DATA_WIDTH]),
            .size       (ch_size[c*REG_DATA_WIDTH +: REG_DATA_WIDTH]),
            .mode       (ch_mode[c*MODE_WIDTH +: MODE_WIDTH]),
            .start      (ch_start[c]),
            .busy       (ch_busy[c])
        );
    end

    // APB FSM; SETUP is the first access cycle, PREADY lands on access cycle WAIT_STATES+1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= APB_IDLE;
            wait_cnt <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PRDATA   <= '0;
        end else begin
            case (state)
                APB_IDLE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    if (PSEL && !PENABLE) begin
                        state    <= APB_SETUP;
                        wait_cnt <= '0;
                        if (WAIT_STATES == 0) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= err_c;
                            PRDATA  <= rd_c;
                        end
                    end
                end
                APB_SETUP, APB_ACCESS: begin
                    if (!PSEL || PREADY) begin
                        state   <= APB_IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                    end else begin
                        state    <= APB_ACCESS;
                        wait_cnt <= wait_cnt + 3'd1;
                        if ((32'(wait_cnt) + 32'd1) == WAIT_STATES) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= err_c;
                            PRDATA  <= rd_c;
                        end
                    end
                end
                default: state <= APB_IDLE;
            endcase
        end
    end

    // Interrupt status (W1C, completion set wins), enable mask and registered INTR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            int_status <= '0;
            int_enable <= '0;
            INTR       <= 1'b0;
        end else begin
            INTR <= |(int_status & int_enable);
            if (wr_commit && glb_hit && (glb_ofs == 32'(GLB_INT_STAT_OFS)))
                int_status <= (int_status & ~PWDATA[NCH-1:0]) | done_set;
            else
                int_status <= int_status | done_set;
            if (wr_commit && glb_hit && (glb_ofs == 32'(GLB_INT_EN_OFS)))
                int_enable <= PWDATA[NCH-1:0];
        end
    end

endmodule

// File: tb/tb_dma_apb_cfg_mc.sv
// Directed self-checking bench for dma_apb_cfg_mc with an APB response scoreboard.
module tb_dma_apb_cfg_mc;
    import dma_apb_cfg_mc_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned WS  = 2;

    logic                          CLK = 1'b0;
    logic                          RST = 1'b1;
    logic                          PSEL = 1'b0;
    logic                          PENABLE = 1'b0;
    logic                          PWRITE = 1'b0;
    logic [REG_ADDR_WIDTH-1:0]     PADDR = '0;
    logic [REG_DATA_WIDTH-1:0]     PWDATA = '0;
    logic [REG_DATA_WIDTH-1:0]     PRDATA;
    logic                          PREADY;
    logic                          PSLVERR;
    logic [NCH*REG_DATA_WIDTH-1:0] ch_src;
    logic [NCH*REG_DATA_WIDTH-1:0] ch_dest;
    logic [NCH*REG_DATA_WIDTH-1:0] ch_size;
    logic [NCH*MODE_WIDTH-1:0]     ch_mode;
    logic [NCH-1:0]                ch_start;
    logic [NCH-1:0]                ch_done = '0;
    logic                          INTR;

    always #5 CLK = ~CLK;

    dma_apb_cfg_mc #(.NCH(NCH), .WAIT_STATES(WS), .CH_STRIDE(32), .GLB_BASE(256)) dut (
        .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .ch_src(ch_src), .ch_dest(ch_dest), .ch_size(ch_size),
        .ch_mode(ch_mode), .ch_start(ch_start), .ch_done(ch_done), .INTR(INTR)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic        want_rd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer; dmask is driven on ch_done so it is sampled on the commit edge.
    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input logic want_rd,
                       input logic [3:0] dmask, input string tag, output int acc);
        exp_t e;
        bit   got;
        sb.push_back(exp_t'{rd: exp_rd, err: exp_err, want_rd: want_rd});
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        acc = 0;
        got = 1'b0;
        while (!got && acc < 16) begin
            @(negedge CLK);
            acc++;
            if (PREADY === 1'b1) got = 1'b1;
        end
        e = sb.pop_front();
        if (!got) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_timeout observed=no_pready expected=pready", tag);
        end else begin
            chk({tag, "_err"}, 32'(PSLVERR), 32'(e.err));
            if (e.want_rd) chk({tag, "_rd"}, PRDATA, e.rd);
            ch_done = dmask;
        end
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; ch_done = '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic err, input string tag);
        int acc;
        apb(1'b1, a, d, 32'h0, err, 1'b0, 4'h0, tag, acc);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic err, input string tag);
        int acc;
        apb(1'b0, a, 32'h0, exp, err, 1'b1, 4'h0, tag, acc);
    endtask

    task automatic pulse_done(input logic [3:0] m);
        @(posedge CLK); #1 ch_done = m;
        @(posedge CLK); #1 ch_done = '0;
    endtask

    initial begin
        int acc;

        // Reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_pready", 32'(PREADY), 32'h0);
        chk("rst_pslverr", 32'(PSLVERR), 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_intr", 32'(INTR), 32'h0);
        chk("rst_start", 32'(ch_start), 32'h0);
        chk("rst_src1", ch_src[63:32], 32'h0);
        chk("rst_mode", 32'(ch_mode), 32'h0);
        @(posedge CLK); #1 RST = 1'b0;

        // Register read-back and PREADY latency
        apb(1'b1, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, "t1_lat_wr", acc);
        chk("t1_wr_access_cycles", 32'(acc), 32'd3);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 3; r++)
                wr(12'(c*32 + r*4), 32'(c*16 + r), 1'b0, "t1_wr");
        for (int c = 0; c < 4; c++) wr(12'(c*32 + 12), 32'h0, 1'b0, "t1_mode0");
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                rd(12'(c*32 + r*4), (r == 3) ? 32'h0 : 32'(c*16 + r), 1'b0, "t1_rd");
        apb(1'b0, 12'h064, 32'h0, 32'h31, 1'b0, 1'b1, 4'h0, "t1_lat_rd", acc);
        chk("t1_rd_access_cycles", 32'(acc), 32'd3);

        // Channel 1 start and completion
        wr(12'h104, 32'h2, 1'b0, "t2_int_en");
        wr(12'h020, 32'h00100007, 1'b0, "t2_src");
        wr(12'h024, 32'h00200002, 1'b0, "t2_dest");
        wr(12'h028, 32'd11, 1'b0, "t2_size");
        wr(12'h02C, 32'h1, 1'b0, "t2_mode");
        @(negedge CLK);
        chk("t2_start_pulse", 32'(ch_start), 32'h2);
        chk("t2_ch_mode", 32'(ch_mode[3:2]), 32'h1);
        chk("t2_ch_src", ch_src[63:32], 32'h00100007);
        chk("t2_ch_dest", ch_dest[63:32], 32'h00200002);
        chk("t2_ch_size", ch_size[63:32], 32'd11);
        @(negedge CLK);
        chk("t2_start_end", 32'(ch_start), 32'h0);
        rd(12'h108, 32'h2, 1'b0, "t2_busy");
        pulse_done(4'b0010);
        @(negedge CLK);
        chk("t2_intr_lag", 32'(INTR), 32'h0);
        @(negedge CLK);
        chk("t2_intr", 32'(INTR), 32'h1);
        rd(12'h02C, 32'h0, 1'b0, "t2_mode_cleared");
        rd(12'h100, 32'h2, 1'b0, "t2_status");
        rd(12'h108, 32'h0, 1'b0, "t2_busy_clr");
        chk("t2_ch_mode_out", 32'(ch_mode[3:2]), 32'h0);
        wr(12'h100, 32'hF, 1'b0, "t2_w1c");

        // Error responses
        wr(12'h048, 32'd5, 1'b0, "t3_size2");
        wr(12'h04C, 32'h2, 1'b0, "t3_mode2");
        wr(12'h040, 32'h1234, 1'b1, "t3_src_busy");
        rd(12'h040, 32'h20, 1'b0, "t3_src_kept");
        wr(12'h04C, 32'h1, 1'b1, "t3_mode_busy");
        rd(12'h04C, 32'h2, 1'b0, "t3_mode_kept");
        wr(12'h06C, 32'h3, 1'b1, "t3_mode3");
        rd(12'h06C, 32'h0, 1'b0, "t3_mode3_kept");
        wr(12'h002, 32'h5, 1'b1, "t3_misalign_wr");
        rd(12'h002, 32'h0, 1'b1, "t3_misalign_rd");
        rd(12'h010, 32'h0, 1'b1, "t3_bad_ofs");
        rd(12'h080, 32'h0, 1'b1, "t3_ch4");
        wr(12'h108, 32'h0, 1'b1, "t3_busy_wr");
        rd(12'h10C, 32'h0, 1'b1, "t3_glb_unmapped");
        pulse_done(4'b0100);
        rd(12'h100, 32'h4, 1'b0, "t3_status2");
        wr(12'h100, 32'hF, 1'b0, "t3_w1c");
        pulse_done(4'b1000);
        rd(12'h100, 32'h0, 1'b0, "t3_idle_done");

        // Completion racing a W1C of the same bit
        wr(12'h104, 32'h1, 1'b0, "t4_int_en");
        wr(12'h00C, 32'h1, 1'b0, "t4_start0");
        apb(1'b1, 12'h100, 32'h1, 32'h0, 1'b0, 1'b0, 4'b0001, "t4_race", acc);
        rd(12'h100, 32'h1, 1'b0, "t4_set_wins");
        chk("t4_intr_on", 32'(INTR), 32'h1);
        wr(12'h100, 32'h1, 1'b0, "t4_w1c");
        @(negedge CLK);
        chk("t4_intr_hold", 32'(INTR), 32'h1);
        @(negedge CLK);
        chk("t4_intr_off", 32'(INTR), 32'h0);
        rd(12'h100, 32'h0, 1'b0, "t4_status_clr");
        rd(12'h108, 32'h0, 1'b0, "t4_busy_clr");

        // Two channels completing together, then a zero-size start
        wr(12'h00C, 32'h1, 1'b0, "t5_start0");
        wr(12'h06C, 32'h2, 1'b0, "t5_start3");
        rd(12'h108, 32'h9, 1'b0, "t5_busy");
        pulse_done(4'b1001);
        rd(12'h100, 32'h9, 1'b0, "t5_status");
        rd(12'h108, 32'h0, 1'b0, "t5_busy_clr");
        wr(12'h100, 32'hF, 1'b0, "t5_w1c");
        wr(12'h028, 32'h0, 1'b0, "t5_size0");
        wr(12'h02C, 32'h1, 1'b0, "t5_zero_start");
        @(negedge CLK);
        chk("t5_no_start_a", 32'(ch_start), 32'h0);
        @(negedge CLK);
        chk("t5_no_start_b", 32'(ch_start), 32'h0);
        rd(12'h100, 32'h2, 1'b0, "t5_zero_status");
        rd(12'h02C, 32'h0, 1'b0, "t5_zero_mode");
        rd(12'h108, 32'h0, 1'b0, "t5_zero_busy");

        // Reset during a busy channel and an in-flight access
        wr(12'h00C, 32'h1, 1'b0, "t6_start0");
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h000;
        @(posedge CLK); #1 PENABLE = 1'b1;
        @(negedge CLK);
        chk("t6_not_ready", 32'(PREADY), 32'h0);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge CLK);
        chk("t6_pready", 32'(PREADY), 32'h0);
        chk("t6_pslverr", 32'(PSLVERR), 32'h0);
        chk("t6_src0", ch_src[31:0], 32'h0);
        chk("t6_size3", ch_size[127:96], 32'h0);
        chk("t6_mode", 32'(ch_mode), 32'h0);
        chk("t6_intr", 32'(INTR), 32'h0);
        @(posedge CLK); #1 RST = 1'b0;
        rd(12'h108, 32'h0, 1'b0, "t6_busy");
        rd(12'h104, 32'h0, 1'b0, "t6_int_en");
        wr(12'h000, 32'hDEADBEEF, 1'b0, "t6_wr");
        rd(12'h000, 32'hDEADBEEF, 1'b0, "t6_rd");

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
